// File: rtl/bexkat2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bexkat2_pkg
// Purpose  : Shared memory-size, FSM-state and byte-lane definitions.
// Revision : 1.0
// ============================================================================
package bexkat2_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_BUS   = 2'd1,
    WB_WB    = 2'd2,
    WB_FAULT = 2'd3
  } wb_state_t;

  // Lane masks at offset 0; sel[3] is the most significant (big-endian offset 0) byte.
  localparam logic [3:0] c_sel_none = 4'b0000;
  localparam logic [3:0] c_sel_byte = 4'b1000;
  localparam logic [3:0] c_sel_half = 4'b1100;
  localparam logic [3:0] c_sel_word = 4'b1111;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_writeback_if
// Purpose  : Wishbone classic bus between the load/store stage and memory.
// Revision : 1.0
// ============================================================================
interface mem_writeback_if import bexkat2_pkg::*; #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic [3:0]    sel_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i;
  logic          ack_i;
  logic          err_i;

  modport master (
    output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    output dat_i, ack_i, err_i
  );
endinterface
`default_nettype wire

// File: rtl/mem_writeback_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Big-endian byte-lane select, store steering, load extraction and
//            alignment check for byte/half/word accesses.
// Revision : 1.0
// ============================================================================
module mem_lane_align import bexkat2_pkg::*; (
  input  wire [1:0]  i_size,
  input  wire [1:0]  i_offset,
  input  wire [31:0] i_sdata,
  input  wire [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_illegal
);

  logic [4:0] w_shift;

  // w_shift is the bit position of the access's least significant lane.
  always_comb begin
    o_sel     = c_sel_none;
    w_shift   = 5'd0;
    o_illegal = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_sel   = c_sel_byte >> i_offset;
        w_shift = {2'b11 - i_offset, 3'b000};
      end
      SZ_HALF: begin
        o_sel     = c_sel_half >> i_offset;
        w_shift   = {2'b10 - i_offset, 3'b000};
        o_illegal = i_offset[0];
      end
      SZ_WORD: begin
        o_sel     = c_sel_word;
        o_illegal = (i_offset != 2'b00);
      end
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_wdata = (i_sdata << w_shift) & lane_mask(o_sel);
  assign o_rdata = (i_rdata & lane_mask(o_sel)) >> w_shift;

endmodule
`default_nettype wire

// File: rtl/mem_writeback.sv
`default_nettype none
// ============================================================================
// Module   : mem_writeback
// Purpose  : Load/store stage: one Wishbone classic cycle per request, then a
//            single-cycle register-file write for loads.
// Revision : 1.0
// ============================================================================
module mem_writeback import bexkat2_pkg::*; #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int REGP    = 4,
  parameter int TIMEOUT = 255
) (
  input  wire             clk_i,
  input  wire             rst_i,
  input  wire             start_i,
  input  wire             load_i,
  input  wire [1:0]       size_i,
  input  wire [AW-1:0]    addr_i,
  input  wire [DW-1:0]    sdata_i,
  input  wire [REGP-1:0]  dest_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            fault_o,
  output logic [REGP-1:0] rf_write_addr,
  output logic [DW-1:0]   rf_write_data,
  output logic [1:0]      rf_write_en,
  mem_writeback_if.master wb
);

  localparam int              c_tmo_w   = $clog2(TIMEOUT + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TIMEOUT);

  localparam logic [1:0] c_st_idle  = WB_IDLE;
  localparam logic [1:0] c_st_bus   = WB_BUS;
  localparam logic [1:0] c_st_wb    = WB_WB;
  localparam logic [1:0] c_st_fault = WB_FAULT;

  logic [1:0]         r_state;
  logic               r_load;
  logic [1:0]         r_size;
  logic [AW-1:0]      r_addr;
  logic [DW-1:0]      r_sdata;
  logic [REGP-1:0]    r_dest;
  logic [DW-1:0]      r_rdata;
  logic [c_tmo_w-1:0] r_tmo;

  logic        w_idle;
  logic        w_bus;
  logic [1:0]  w_al_size;
  logic [1:0]  w_al_off;
  logic [3:0]  w_sel;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata;
  logic        w_illegal;

  assign w_idle = (r_state == c_st_idle);
  assign w_bus  = (r_state == c_st_bus);

  // In IDLE the aligner checks the live request; afterwards it serves the captured one.
  assign w_al_size = w_idle ? size_i       : r_size;
  assign w_al_off  = w_idle ? addr_i[1:0]  : r_addr[1:0];

  mem_lane_align u_align (
    .i_size    (w_al_size),
    .i_offset  (w_al_off),
    .i_sdata   (r_sdata),
    .i_rdata   (wb.dat_i),
    .o_sel     (w_sel),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= c_st_idle;
      r_load  <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_sdata <= '0;
      r_dest  <= '0;
      r_rdata <= '0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start_i) begin
            r_load  <= load_i;
            r_size  <= size_i;
            r_addr  <= addr_i;
            r_sdata <= sdata_i;
            r_dest  <= dest_i;
            r_tmo   <= '0;
            r_state <= w_illegal ? c_st_fault : c_st_bus;
          end
        end
        c_st_bus: begin
          if (wb.err_i) begin
            r_state <= c_st_fault;
          end else if (wb.ack_i) begin
            if (r_load) begin
              r_rdata <= w_rdata;
            end
            r_state <= c_st_wb;
          end else if (r_tmo == c_tmo_max) begin
            r_state <= c_st_fault;
          end else begin
            r_tmo <= r_tmo + c_tmo_w'(1);
          end
        end
        // Stores also pass through WB so done_o lands inside the busy window.
        c_st_wb:    r_state <= c_st_idle;
        c_st_fault: r_state <= c_st_idle;
        default:    r_state <= c_st_idle;
      endcase
    end
  end

  assign busy_o        = !w_idle;
  assign done_o        = (r_state == c_st_wb);
  assign fault_o       = (r_state == c_st_fault);
  assign rf_write_en   = (done_o && r_load) ? r_size : 2'b00;
  assign rf_write_addr = r_dest;
  assign rf_write_data = r_rdata;

  assign wb.cyc_o = w_bus;
  assign wb.stb_o = w_bus;
  assign wb.we_o  = w_bus && !r_load;
  assign wb.sel_o = w_bus ? w_sel : 4'b0000;
  assign wb.adr_o = w_bus ? {r_addr[AW-1:2], 2'b00} : '0;
  assign wb.dat_o = w_bus ? w_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_writeback
// Purpose  : Self-checking bench for mem_writeback (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_mem_writeback;

  localparam int TO = 255;
  localparam int T_ACK = 0, T_ERR = 1, T_BOTH = 2, T_NONE = 3;

  typedef struct {
    logic        ld;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [3:0]  dest;
    logic [31:0] rdata;
    int          wait_n;
    int          term;
    logic        illegal;
    logic [3:0]  sel;
    logic [31:0] lane;
    logic [31:0] rf;
  } vec_t;

  typedef struct {
    logic        fault;
    logic        ld;
    logic [1:0]  en;
    logic [31:0] data;
    logic [3:0]  dest;
    int          cyc;
    logic        timed;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i, load_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, sdata_i;
  logic [3:0]  dest_i;
  logic        busy_o, done_o, fault_o;
  logic [3:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [1:0]  rf_write_en;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc_cnt = 0;
  exp_t sb[$];
  vec_t vecs[$];

  mem_writeback_if #(.AW(32), .DW(32)) wb ();

  mem_writeback #(.AW(32), .DW(32), .REGP(4), .TIMEOUT(TO)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .load_i        (load_i),
    .size_i        (size_i),
    .addr_i        (addr_i),
    .sdata_i       (sdata_i),
    .dest_i        (dest_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .fault_o       (fault_o),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .rf_write_en   (rf_write_en),
    .wb            (wb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bytes_of(input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{sel[i]}};
    return m;
  endfunction

  function automatic vec_t mk(input logic ld, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] sd, input logic [3:0] d, input logic [31:0] rd,
                              input int w, input int t, input logic ill, input logic [3:0] sel,
                              input logic [31:0] lane, input logic [31:0] rf);
    vec_t v;
    v.ld = ld; v.sz = sz; v.addr = a; v.sdata = sd; v.dest = d; v.rdata = rd;
    v.wait_n = w; v.term = t; v.illegal = ill; v.sel = sel; v.lane = lane; v.rf = rf;
    return v;
  endfunction

  // Scoreboard consumer: every done/fault pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_i && (done_o || fault_o)) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {62'd0, done_o, fault_o}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("fault_o", fault_o, e.fault);
        chk("done_o", done_o, !e.fault);
        chk("rf_write_en", rf_write_en, e.en);
        if (!e.fault && e.ld) begin
          chk("rf_write_data", rf_write_data, e.data);
          chk("rf_write_addr", rf_write_addr, e.dest);
        end
        if (e.timed) chk("latency", cyc_cnt, e.cyc);
      end
    end
    if (!rst_i && rf_write_en != 2'b00 && !done_o) chk("rf_en_stray", rf_write_en, 2'b00);
  end

  task automatic run_vec(input vec_t v);
    int   c0;
    int   n;
    exp_t e;
    @(posedge clk); #1;
    c0 = cyc_cnt;
    start_i = 1'b1; load_i = v.ld; size_i = v.sz; addr_i = v.addr; sdata_i = v.sdata; dest_i = v.dest;
    e.fault = v.illegal || (v.term != T_ACK);
    e.ld    = v.ld;
    e.en    = (v.ld && !e.fault) ? v.sz : 2'b00;
    e.data  = v.rf;
    e.dest  = v.dest;
    e.cyc   = c0 + (v.illegal ? 1 : 2 + v.wait_n);
    e.timed = v.illegal || (v.term != T_NONE);
    sb.push_back(e);
    @(posedge clk); #1;
    start_i = 1'b0; size_i = 2'b00; addr_i = 32'hFFFF_FFFF; sdata_i = 32'hFFFF_FFFF;
    if (v.illegal) begin
      chk("illegal_no_cyc", wb.cyc_o, 1'b0);
      @(posedge clk); #1;
      chk("illegal_busy_c2", busy_o, 1'b0);
      chk("illegal_no_cyc_c2", wb.cyc_o, 1'b0);
    end else begin
      chk("cyc_o", wb.cyc_o, 1'b1);
      chk("stb_o", wb.stb_o, 1'b1);
      chk("we_o", wb.we_o, !v.ld);
      chk("sel_o", wb.sel_o, v.sel);
      chk("adr_o", wb.adr_o, v.addr & 32'hFFFF_FFFC);
      if (!v.ld) chk("dat_o", wb.dat_o & bytes_of(v.sel), v.lane);
      wb.dat_i = v.rdata;
      if (v.term == T_NONE) begin
        n = 0;
        while (wb.stb_o && n < 600) begin
          n++;
          @(posedge clk); #1;
        end
        chk("timeout_len_ok", (n >= TO && n <= TO + 1), 1'b1);
      end else begin
        repeat (v.wait_n) begin @(posedge clk); #1; end
        wb.ack_i = (v.term == T_ACK) || (v.term == T_BOTH);
        wb.err_i = (v.term == T_ERR) || (v.term == T_BOTH);
        @(posedge clk); #1;
        wb.ack_i = 1'b0; wb.err_i = 1'b0;
      end
    end
    n = 0;
    while (busy_o && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("return_to_idle", busy_o, 1'b0);
  endtask

  initial begin : wdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int   c0;
    exp_t e;
    rst_i = 1'b1; start_i = 1'b0; load_i = 1'b0; size_i = 2'b00;
    addr_i = '0; sdata_i = '0; dest_i = '0;
    wb.dat_i = '0; wb.ack_i = 1'b0; wb.err_i = 1'b0;

    vecs.push_back(mk(1, 2'b01, 32'h1003, 0, 4'd5, 32'hAABBCCDD, 0, T_ACK, 0, 4'b0001, 0, 32'h000000DD));
    vecs.push_back(mk(0, 2'b10, 32'h2002, 32'h1234, 4'd0, 0, 0, T_ACK, 0, 4'b0011, 32'h00001234, 0));
    vecs.push_back(mk(1, 2'b11, 32'h3001, 0, 4'd6, 0, 0, T_ACK, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 2'b10, 32'h4000, 0, 4'd1, 32'h89ABCDEF, 2, T_ACK, 0, 4'b1100, 0, 32'h000089AB));
    vecs.push_back(mk(1, 2'b10, 32'h4002, 0, 4'd2, 32'h89ABCDEF, 0, T_ACK, 0, 4'b0011, 0, 32'h0000CDEF));
    vecs.push_back(mk(1, 2'b01, 32'h5000, 0, 4'd7, 32'h89ABCDEF, 0, T_ACK, 0, 4'b1000, 0, 32'h00000089));
    vecs.push_back(mk(1, 2'b01, 32'h5001, 0, 4'd8, 32'h89ABCDEF, 1, T_ACK, 0, 4'b0100, 0, 32'h000000AB));
    vecs.push_back(mk(1, 2'b01, 32'h5003, 0, 4'd9, 32'hFF00FF80, 0, T_ACK, 0, 4'b0001, 0, 32'h00000080));
    vecs.push_back(mk(0, 2'b01, 32'h6001, 32'hA5, 4'd0, 0, 0, T_ACK, 0, 4'b0100, 32'h00A50000, 0));
    vecs.push_back(mk(0, 2'b11, 32'h7000, 32'hDEADBEEF, 4'd0, 0, 0, T_ACK, 0, 4'b1111, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 2'b11, 32'h8004, 0, 4'd15, 32'h12345678, 0, T_ACK, 0, 4'b1111, 0, 32'h12345678));
    vecs.push_back(mk(0, 2'b00, 32'h9000, 0, 4'd0, 0, 0, T_ACK, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 2'b10, 32'h9001, 0, 4'd3, 0, 0, T_ACK, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 2'b11, 32'hA000, 0, 4'd4, 32'h55555555, 0, T_ERR, 0, 4'b1111, 0, 0));
    vecs.push_back(mk(1, 2'b11, 32'hA004, 0, 4'd4, 32'h66666666, 1, T_BOTH, 0, 4'b1111, 0, 0));
    vecs.push_back(mk(1, 2'b01, 32'hC002, 0, 4'd2, 32'h11223344, 0, T_NONE, 0, 4'b0010, 0, 0));
    vecs.push_back(mk(0, 2'b01, 32'hC003, 32'h7E, 4'd0, 0, 3, T_ACK, 0, 4'b0001, 32'h0000007E, 0));
    vecs.push_back(mk(0, 2'b10, 32'hD000, 32'hFFFF5AC3, 4'd0, 0, 0, T_ACK, 0, 4'b1100, 32'h5AC30000, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done_fault", {done_o, fault_o}, 2'b00);
    chk("rst_rf", {rf_write_en, rf_write_addr, rf_write_data}, 38'd0);
    chk("rst_bus", {wb.cyc_o, wb.stb_o, wb.we_o, wb.sel_o, wb.adr_o, wb.dat_o}, 71'd0);
    rst_i = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset pulsed while the strobe is up: bus drops immediately, nothing completes.
    @(posedge clk); #1;
    start_i = 1'b1; load_i = 1'b1; size_i = 2'b11; addr_i = 32'hE000; dest_i = 4'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("pre_rst_stb", wb.stb_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_bus", {wb.cyc_o, wb.stb_o, wb.sel_o, wb.adr_o}, 38'd0);
    chk("async_rst_status", {busy_o, done_o, fault_o, rf_write_en}, 5'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    run_vec(vecs[0]);

    // start_i held through BUS and WB, then once more in IDLE: two bus cycles exactly.
    @(posedge clk); #1;
    c0 = cyc_cnt;
    load_i = 1'b1; size_i = 2'b01; addr_i = 32'h1003; dest_i = 4'd3; wb.dat_i = 32'hAABBCCDD;
    e.fault = 1'b0; e.ld = 1'b1; e.en = 2'b01; e.data = 32'h000000DD; e.dest = 4'd3; e.timed = 1'b1;
    e.cyc = c0 + 2; sb.push_back(e);
    e.cyc = c0 + 5; sb.push_back(e);
    for (int k = 0; k < 10; k++) begin
      start_i  = (k <= 3);
      wb.ack_i = wb.stb_o;
      chk($sformatf("held_start_stb_c%0d", k), wb.stb_o, (k == 1 || k == 4));
      @(posedge clk); #1;
    end
    start_i = 1'b0; wb.ack_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
